mux_a: RTL and testbench
========================

Name: mux_a

Overview:
- Accumulator-input selector for the BIP I datapath.
- Routes one of three 16-bit sources (data memory, instruction immediate, ALU result) to the accumulator input (combinational path, no latency).
- Also holds the registered accumulator value and the status flags derived from it.
- Sits between the memory/decode/ALU outputs and the accumulator consumers; SelA and WrAcc come from the control unit.

Parameters:
- WIDTH, 16, data width of all source buses, Acc and AccReg.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- Memory  input  WIDTH  data-memory read value
- Immediate  input  WIDTH  immediate operand from the instruction word
- Alu  input  WIDTH  ALU result
- SelA  input  2  source select
- WrAcc  input  1  accumulator write enable
- Acc  output  WIDTH  selected source (combinational)
- AccReg  output  WIDTH  registered accumulator value
- Zero  output  1  high when AccReg == 0
- Neg  output  1  AccReg[WIDTH-1]

Behaviour:
- Acc is purely combinational from SelA and the sources, with zero-cycle latency:
  - SelA=0 -> Memory
  - SelA=1 -> Immediate
  - SelA=2 -> Alu
  - SelA=3 -> all zeros (default build)
- Acc does not depend on clk or reset, except through SelA=3 when the optional feature is enabled.
- Any change on the selected source propagates to Acc immediately. Changes on unselected sources have no effect on Acc.
- SelA containing X/Z: Acc is don't-care. No latch inference is allowed; every SelA code must have a defined assignment.
- AccReg:
  - reset high (asynchronous) -> AccReg = 0 immediately, regardless of clk.
  - Otherwise, on rising clk: if WrAcc=1 then AccReg <= Acc, else AccReg holds.
  - Write latency is 1 cycle: the value is visible on AccReg after the edge.
  - If reset is asserted mid-operation, AccReg clears at once. The first write after deassertion takes effect on the next rising edge with WrAcc=1.
  - If reset and WrAcc are both active at an edge, reset wins.
- Flags:
  - Zero and Neg are combinational functions of AccReg only, never of Acc.
  - Reset values: AccReg=0, Zero=1, Neg=0.
- Width rules: no arithmetic in this block. All buses are the same WIDTH with no extension or truncation.

Optional Feature:
- Macro: MUX_A_HOLD_EN.
- Defined: SelA=3 selects AccReg onto Acc. A write with SelA=3 and WrAcc=1 therefore re-stores the current value (hold/feedback path). During reset, Acc = 0 when SelA=3.
- Undefined: SelA=3 drives Acc to all zeros. A write with SelA=3 and WrAcc=1 clears the accumulator.
- No other behaviour differs between the two builds.

Test Plan:
- All inputs 0, SelA=0, reset pulsed -> Acc=0, AccReg=0, Zero=1, Neg=0.
- Memory=247, SelA=0 -> Acc=247 with no clock edge. Then WrAcc=1 and one clk edge -> AccReg=247, Zero=0.
- Immediate=135, SelA=1 (Memory still 247) -> Acc=135. Change Memory to 1 -> Acc stays 135. With WrAcc=0 over 3 edges -> AccReg stays 247.
- Alu=22222, SelA=2 -> Acc=22222. Then Alu=16'h8001 with WrAcc=1 and one edge -> AccReg=16'h8001, Neg=1, Zero=0.
- SelA=3 -> Acc=0 (default build) or Acc=AccReg (MUX_A_HOLD_EN build). Then WrAcc=1 and one edge -> AccReg=0 (default build) or AccReg unchanged (MUX_A_HOLD_EN build).
- AccReg=22222, assert reset between clock edges with WrAcc=1 -> AccReg=0 and Zero=1 immediately. Hold reset across an edge -> AccReg stays 0. After deassertion, the next edge loads Acc.

Source files
------------

// File: rtl/mux_a.sv
// Accumulator-input selector: zero-latency source mux onto Acc, 1-cycle registered AccReg with Zero/Neg flags.
// Optional MUX_A_HOLD_EN: SelA=3 feeds AccReg back onto Acc instead of driving zeros.
module mux_a #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Memory,
  input  logic [WIDTH-1:0] Immediate,
  input  logic [WIDTH-1:0] Alu,
  input  logic [1:0]       SelA,
  input  logic             WrAcc,
  output logic [WIDTH-1:0] Acc,
  output logic [WIDTH-1:0] AccReg,
  output logic             Zero,
  output logic             Neg
);

  logic [WIDTH-1:0] acc_sel;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_q;

  always_comb begin
    acc_sel = '0;
    case (SelA)
      2'd0:    acc_sel = Memory;
      2'd1:    acc_sel = Immediate;
      2'd2:    acc_sel = Alu;
`ifdef MUX_A_HOLD_EN
      // acc_q is already zero while reset is held, so the feedback path reads 0 then.
      2'd3:    acc_sel = acc_q;
`else
      2'd3:    acc_sel = '0;
`endif
      default: acc_sel = '0;
    endcase
  end

  assign Acc = acc_sel;

  always_comb begin
    acc_d = acc_q;
    if (WrAcc) begin
      acc_d = acc_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign AccReg = acc_q;
  assign Zero   = (acc_q == '0);
  assign Neg    = acc_q[WIDTH-1];

endmodule

// File: tb/tb_mux_a.sv
// Directed bench for mux_a: table of combinational select vectors plus hand-written register/reset sequences.
module tb_mux_a;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] Memory;
  logic [W-1:0] Immediate;
  logic [W-1:0] Alu;
  logic [1:0]   SelA;
  logic         WrAcc;
  logic [W-1:0] Acc;
  logic [W-1:0] AccReg;
  logic         Zero;
  logic         Neg;

  int errors = 0;
  int checks = 0;

  mux_a #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Memory    (Memory),
    .Immediate (Immediate),
    .Alu       (Alu),
    .SelA      (SelA),
    .WrAcc     (WrAcc),
    .Acc       (Acc),
    .AccReg    (AccReg),
    .Zero      (Zero),
    .Neg       (Neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] mem;
    logic [W-1:0] imm;
    logic [W-1:0] alu;
    logic [1:0]   sel;
    logic [W-1:0] exp_acc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_sel3_acc;
  logic [W-1:0] exp_sel3_reg;

  initial begin
    reset = 1'b1; Memory = '0; Immediate = '0; Alu = '0; SelA = 2'd0; WrAcc = 1'b0;

    // AccReg is zero throughout the table, so SelA=3 reads 0 in both builds.
    vecs[0] = '{16'h1234, 16'h5678, 16'h9abc, 2'd0, 16'h1234};
    vecs[1] = '{16'h1234, 16'h5678, 16'h9abc, 2'd1, 16'h5678};
    vecs[2] = '{16'h1234, 16'h5678, 16'h9abc, 2'd2, 16'h9abc};
    vecs[3] = '{16'h1234, 16'h5678, 16'h9abc, 2'd3, 16'h0000};
    vecs[4] = '{16'hffff, 16'h0000, 16'h0000, 2'd0, 16'hffff};
    vecs[5] = '{16'h0000, 16'h8000, 16'hffff, 2'd1, 16'h8000};
    vecs[6] = '{16'haaaa, 16'h5555, 16'h0001, 2'd2, 16'h0001};
    vecs[7] = '{16'hffff, 16'hffff, 16'hffff, 2'd3, 16'h0000};

    #12;
    chk("rst_accreg", AccReg, 16'd0);
    chk("rst_zero", {15'd0, Zero}, 16'd1);
    reset = 1'b0;
    #1;
    chk("post_rst_acc", Acc, 16'd0);
    chk("post_rst_accreg", AccReg, 16'd0);
    chk("post_rst_zero", {15'd0, Zero}, 16'd1);
    chk("post_rst_neg", {15'd0, Neg}, 16'd0);

    for (int i = 0; i < 8; i++) begin
      Memory = vecs[i].mem; Immediate = vecs[i].imm; Alu = vecs[i].alu; SelA = vecs[i].sel;
      #1;
      chk($sformatf("vec%0d_acc", i), Acc, vecs[i].exp_acc);
      chk($sformatf("vec%0d_accreg", i), AccReg, 16'd0);
    end

    Memory = 16'd0; Immediate = 16'd0; Alu = 16'd0;
    tick();
    Memory = 16'd247; SelA = 2'd0;
    #1;
    chk("mem_comb", Acc, 16'd247);
    WrAcc = 1'b1;
    tick();
    WrAcc = 1'b0;
    chk("mem_write", AccReg, 16'd247);
    chk("mem_write_zero", {15'd0, Zero}, 16'd0);

    Immediate = 16'd135; SelA = 2'd1;
    #1;
    chk("imm_comb", Acc, 16'd135);
    Memory = 16'd1;
    #1;
    chk("imm_unsel_mem", Acc, 16'd135);
    tick(); tick(); tick();
    chk("hold_3_edges", AccReg, 16'd247);

    Alu = 16'd22222; SelA = 2'd2;
    #1;
    chk("alu_comb", Acc, 16'd22222);
    Alu = 16'h8001; WrAcc = 1'b1;
    tick();
    WrAcc = 1'b0;
    chk("alu_write", AccReg, 16'h8001);
    chk("alu_neg", {15'd0, Neg}, 16'd1);
    chk("alu_zero", {15'd0, Zero}, 16'd0);

`ifdef MUX_A_HOLD_EN
    exp_sel3_acc = 16'h8001; exp_sel3_reg = 16'h8001;
`else
    exp_sel3_acc = 16'h0000; exp_sel3_reg = 16'h0000;
`endif
    SelA = 2'd3;
    #1;
    chk("sel3_comb", Acc, exp_sel3_acc);
    WrAcc = 1'b1;
    tick();
    WrAcc = 1'b0;
    chk("sel3_write", AccReg, exp_sel3_reg);
    chk("sel3_zero", {15'd0, Zero}, {15'd0, exp_sel3_reg == 16'd0});

    SelA = 2'd2; Alu = 16'd22222; WrAcc = 1'b1;
    tick();
    chk("load_22222", AccReg, 16'd22222);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_accreg", AccReg, 16'd0);
    chk("async_rst_zero", {15'd0, Zero}, 16'd1);
    SelA = 2'd3;
    #1;
    chk("rst_sel3_acc", Acc, 16'd0);
    SelA = 2'd2;
    tick();
    chk("rst_over_edge", AccReg, 16'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_hold", AccReg, 16'd0);
    tick();
    chk("first_write_after_rst", AccReg, 16'd22222);
    WrAcc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
